// File: rtl/cmp_sched_pkg.sv
// -----------------------------------------------------------------------------
// cmp_sched_pkg
// Shared types and sizing helpers for the cmp_sched_ctrl compare engine.
//   state_e    : controller FSM states (IDLE, COMPARE, DONE)
//   num_chunks : number of CHUNK_W slices in a DATA_W operand
//   id_width   : requester-id width, never narrower than one bit
// -----------------------------------------------------------------------------
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic int num_chunks(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/chunk_eq_cmp.sv
// -----------------------------------------------------------------------------
// chunk_eq_cmp
// Shared combinational chunk comparator.
// Ports:
//   x, y : CHUNK_W-bit operands
//   eq   : 1 when x == y
// -----------------------------------------------------------------------------
module chunk_eq_cmp #(
  parameter int CHUNK_W = 2
) (
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  output logic               eq
);

  assign eq = (x == y);

endmodule

// File: rtl/cmp_sched_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_sched_ctrl
// Round-robin arbitrated, chunk-serial wide equality compare engine. One
// requester is granted, its operand pair is captured, then walked LSB chunk
// first through the single shared chunk_eq_cmp. The result is returned with
// the requester id and held until the consumer accepts it.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid / req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          : packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid / rsp_ready : result handshake
//   rsp_eq, rsp_id        : equality result and granted requester index
//   busy                  : high whenever the FSM is not in IDLE
//
// Build option: define CMP_SCHED_EARLY_EXIT_EN to finish on the first
// mismatching chunk instead of always walking every chunk.
// -----------------------------------------------------------------------------
module cmp_sched_ctrl
  import cmp_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int CHUNK_W = 2,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_eq,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
);

  localparam int NUM_CHUNKS = num_chunks(DATA_W, CHUNK_W);
  localparam int CIW        = (NUM_CHUNKS <= 1) ? 1 : $clog2(NUM_CHUNKS);

  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
    $error("cmp_sched_ctrl: DATA_W (%0d) must be a multiple of CHUNK_W (%0d)",
           DATA_W, CHUNK_W);
  end

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [CIW-1:0]     chunk_idx_q, chunk_idx_d;
  logic               acc_q, acc_d;
  logic               rsp_eq_q, rsp_eq_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;

  logic               grant_found;
  logic [IDW-1:0]     grant;
  logic               chunk_eq;
  logic [CHUNK_W-1:0] chunk_a, chunk_b;

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = IDW'(idx);
      end
    end
  end

  assign chunk_a = a_q[chunk_idx_q*CHUNK_W +: CHUNK_W];
  assign chunk_b = b_q[chunk_idx_q*CHUNK_W +: CHUNK_W];

  chunk_eq_cmp #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_eq_cmp (
    .x  (chunk_a),
    .y  (chunk_b),
    .eq (chunk_eq)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    chunk_idx_d  = chunk_idx_q;
    acc_d        = acc_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        // grant_found implies req_valid[grant], so ready here is the handshake.
        if (grant_found) begin
          req_ready    = NUM_REQ'(1) << grant;
          a_d          = req_a[grant*DATA_W +: DATA_W];
          b_d          = req_b[grant*DATA_W +: DATA_W];
          rsp_id_d     = grant;
          last_grant_d = grant;
          chunk_idx_d  = '0;
          acc_d        = 1'b1;
          state_d      = COMPARE;
        end
      end
      COMPARE: begin
        acc_d = acc_q & chunk_eq;
        if (chunk_idx_q == CIW'(NUM_CHUNKS - 1)) begin
          rsp_eq_d    = acc_q & chunk_eq;
          chunk_idx_d = '0;
          state_d     = DONE;
        end else begin
          chunk_idx_d = chunk_idx_q + CIW'(1);
        end
`ifdef CMP_SCHED_EARLY_EXIT_EN
        if (!chunk_eq) begin
          rsp_eq_d    = 1'b0;
          chunk_idx_d = '0;
          state_d     = DONE;
        end
`endif
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      chunk_idx_q  <= '0;
      acc_q        <= 1'b1;
      rsp_eq_q     <= 1'b0;
      rsp_id_q     <= '0;
      // Pointing at the highest index makes requester 0 the first candidate.
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      chunk_idx_q  <= chunk_idx_d;
      acc_q        <= acc_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_eq    = rsp_eq_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/cmp_sched_ctrl.md
Name: cmp_sched_ctrl

Overview:
- Arbitrated, sequenced wide-equality compare engine.
- NUM_REQ requesters each offer an operand pair (a, b) of DATA_W bits.
- The block grants one requester round-robin, then walks the operands CHUNK_W bits per cycle through a single shared chunk comparator, LSB chunk first.
- It returns a registered equality result tagged with the requester id.
- It sits between requesting datapaths and the shared bitwise comparator resource, and serialises its use.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- DATA_W, 8, operand width per requester.
- CHUNK_W, 2, bits compared per cycle. DATA_W must be a multiple of CHUNK_W; violation is an elaboration-time $error.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_W  operand A; requester i occupies [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B; same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_eq  output  1  1 when a == b for the granted pair.
- rsp_id  output  IDW  granted requester index, IDW = max(1, $clog2(NUM_REQ)).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, req_ready=0, rsp_valid=0, rsp_eq=0, rsp_id=0, busy=0, chunk_idx=0, acc=1. The round-robin pointer is set so requester 0 has highest priority.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - grant = first asserted req_valid, searching from last_grant+1 with wrap.
  - req_ready[grant] is asserted combinationally, only in IDLE, only for the winner.
  - On handshake: capture a and b into internal registers, rsp_id<=grant, last_grant<=grant, chunk_idx<=0, acc<=1, go to COMPARE.
  - No req_valid: stay in IDLE.
- COMPARE:
  - Each cycle compare chunk chunk_idx via chunk_eq_cmp; acc <= acc & chunk_eq; chunk_idx++.
  - On the last chunk (chunk_idx == NUM_CHUNKS-1): rsp_eq <= acc & chunk_eq, go to DONE.
  - req_ready = 0 throughout.
  - Captured operands are immune to later changes on the req_* inputs.
- DONE:
  - rsp_valid=1; rsp_eq and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - A new grant is not possible in the same cycle; the next accept is earliest one cycle after the response handshake.
- Latency:
  - Accept at edge E0 puts rsp_valid high after edge E0+NUM_CHUNKS (4 cycles with defaults).
  - Throughput with rsp_ready tied high: one compare per NUM_CHUNKS+2 cycles.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ grants.
  - Simultaneous requests resolve by round-robin, never by fixed priority (except the first grant after reset).
- Back-pressure: rsp_ready low holds DONE indefinitely; no requests are accepted meanwhile.
- Reset mid-operation (in COMPARE or DONE):
  - The in-flight compare is abandoned and no response is issued.
  - All outputs return to reset values immediately.
- req_valid dropping before a grant is legal; no request is captured.

Optional Feature:
- Macro: CMP_SCHED_EARLY_EXIT_EN.
- Defined: in COMPARE, a chunk mismatch goes straight to DONE with rsp_eq<=0. rsp_valid then rises after edge E0+k, where k = (index of the first mismatching chunk)+1. Equal operands still take NUM_CHUNKS cycles.
- Undefined: fixed latency NUM_CHUNKS regardless of the data.

Decomposition:
- Package cmp_sched_pkg holds:
  - the state enum typedef (IDLE, COMPARE, DONE);
  - function num_chunks(DATA_W, CHUNK_W);
  - function id_width(NUM_REQ).
- Sub-module chunk_eq_cmp: combinational CHUNK_W-bit equality, output eq = (x == y). This is the shared resource and is instantiated exactly once.

Test Plan:
1. Defaults; req0 with a=8'hA5, b=8'hA5; rsp_ready=1. Expect rsp_eq=1 and rsp_id=0, with rsp_valid 4 cycles after accept.
2. req0 with a=8'hA5, b=8'hA4. Expect rsp_eq=0 after 4 cycles. With CMP_SCHED_EARLY_EXIT_EN defined, expect rsp_valid 1 cycle after accept (chunk 0 mismatch).
3. Both requesters held valid for 6 grants, all pairs equal. Expect rsp_id sequence 0,1,0,1,0,1.
4. Hold rsp_ready=0 for 10 cycles in DONE with req1 valid. Expect rsp_valid, rsp_eq and rsp_id stable, and req_ready=0 throughout. After rsp_ready pulses, expect req1 granted 1 cycle later.
5. Assert reset_n=0 two cycles into COMPARE. Expect rsp_valid=0, busy=0 and state IDLE immediately. After release, a fresh req1 with a=b=8'h3C gives rsp_eq=1 and rsp_id=1.
6. Change req_a on req0 from 8'h0F to 8'hF0 during COMPARE of a captured pair 8'h0F/8'h0F. Expect rsp_eq=1 (captured values used).
